// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI target that oversamples sclk/pico/cs in the local clock domain
module spi_peripheral #(
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic       sclk_i,
    input  logic       pico_i,
    input  logic       cs_i,
    output logic       poci_o,
    output logic       poci_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       underrun_o,
    output logic       busy_o
);

    // Depths below two would not give a metastability margin.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [SS-1:0] sclk_sync_q;
    logic [SS-1:0] cs_sync_q;
    logic [SS-1:0] pico_sync_q;
    logic          sclk_prev_q;
    logic          cs_prev_q;

    logic [7:0]    hold_q;
    logic          hold_full_q;
    logic [7:0]    shift_tx_q;
    logic [7:0]    shift_rx_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          underrun_q;
    // CPHA=1: the next leading edge is the first of a frame and must not shift.
    logic          first_q;
    // CPHA=0: the 8th sample is in; the next trailing edge loads instead of shifting.
    logic          done_q;

    logic sclk_s, cs_s, pico_s, active;
    logic cs_fall, cs_rise, lead, trail;
    logic sample_edge, shift_edge, last_sample, load, do_shift, handshake;
    logic [7:0] rx_next;

    assign sclk_s = sclk_sync_q[SS-1];
    assign cs_s   = cs_sync_q[SS-1];
    assign pico_s = pico_sync_q[SS-1];
    assign active = ~cs_s;

    assign cs_fall = cs_prev_q & ~cs_s;
    assign cs_rise = ~cs_prev_q & cs_s;
    assign lead    = active & (sclk_prev_q == CPOL) & (sclk_s != CPOL);
    assign trail   = active & (sclk_prev_q != CPOL) & (sclk_s == CPOL);

    assign sample_edge = CPHA ? trail : lead;
    assign shift_edge  = CPHA ? lead : trail;
    assign last_sample = sample_edge & (bit_cnt_q == 3'd7);
    assign load        = cs_fall | (CPHA ? last_sample : (shift_edge & done_q));
    assign do_shift    = shift_edge & ~load & (CPHA ? ~first_q : ~done_q);
    assign handshake   = tx_valid_i & ~hold_full_q;
    assign rx_next     = {shift_rx_q[6:0], pico_s};

    assign poci_o     = active & shift_tx_q[7];
    assign poci_oe_o  = active;
    assign busy_o     = active;
    assign tx_ready_o = ~hold_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;

    // Synchronize the SPI pins and keep one previous value for edge detection.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sclk_sync_q <= {SS{CPOL}};
            cs_sync_q   <= '1;
            pico_sync_q <= '0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SS-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SS-2:0], cs_i};
            pico_sync_q <= {pico_sync_q[SS-2:0], pico_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // Transmit holding register, frame loading, bit shifting and byte completion.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_tx_q  <= 8'h00;
            shift_rx_q  <= 8'h00;
            bit_cnt_q   <= 3'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            // A handshake in a load cycle fills holding for the following frame.
            if (handshake) begin
                hold_q      <= tx_data_i;
                hold_full_q <= 1'b1;
            end else if (load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end

            if (cs_rise) begin
                bit_cnt_q  <= 3'd0;
                shift_rx_q <= 8'h00;
                shift_tx_q <= 8'h00;
                first_q    <= 1'b0;
                done_q     <= 1'b0;
            end else if (active) begin
                if (sample_edge) begin
                    shift_rx_q <= rx_next;
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_q  <= rx_next;
                        rx_valid_q <= 1'b1;
                        if (!CPHA) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                // A new select restarts the bit count even after a glitched frame.
                if (cs_fall) begin
                    bit_cnt_q  <= 3'd0;
                    shift_rx_q <= 8'h00;
                end
                if (load) begin
                    shift_tx_q <= hold_full_q ? hold_q : 8'h00;
                    underrun_q <= ~hold_full_q;
                    first_q    <= 1'b1;
                    done_q     <= 1'b0;
                end else begin
                    if (do_shift) begin
                        shift_tx_q <= {shift_tx_q[6:0], 1'b0};
                    end
                    if (lead) begin
                        first_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
